// File: rtl/std_cache_pkg.sv
// ---------------------------------------------------------------------------
// std_cache_pkg : shared data-cache geometry, MSHR state type and helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package std_cache_pkg;

  localparam int unsigned DCACHE_SET_ASSOC   = 8;
  localparam int unsigned DCACHE_SET_IDX_W   = $clog2(DCACHE_SET_ASSOC);
  localparam int unsigned DCACHE_BYTE_OFFSET = 4;

  typedef enum logic [1:0] {
    MSHR_FREE     = 2'd0,
    MSHR_PENDING  = 2'd1,
    MSHR_INFLIGHT = 2'd2
  } mshr_state_e;

  // One-hot of the lowest-index way whose valid bit is clear.
  function automatic logic [DCACHE_SET_ASSOC-1:0] get_victim_cl(
    input logic [DCACHE_SET_ASSOC-1:0] valid_i
  );
    logic [DCACHE_SET_ASSOC-1:0] oh;
    oh = '0;
    for (int i = DCACHE_SET_ASSOC - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [DCACHE_SET_IDX_W-1:0] one_hot_to_bin(
    input logic [DCACHE_SET_ASSOC-1:0] oh_i
  );
    logic [DCACHE_SET_IDX_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < DCACHE_SET_ASSOC; i++) begin
      if (oh_i[i]) bin = bin | DCACHE_SET_IDX_W'(i);
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/std_cache_mshr_file_fifo.sv
// ---------------------------------------------------------------------------
// std_cache_mshr_file_fifo : age FIFO holding MSHR indices in allocation order
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module std_cache_mshr_file_fifo #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]        cnt_q, cnt_d;
  logic                  full, do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (PTR_W + 1)'(DEPTH));
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  // Head reads as zero while empty so the issued index is defined after reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + (PTR_W + 1)'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/std_cache_mshr_file.sv
// ---------------------------------------------------------------------------
// std_cache_mshr_file : multi-entry miss-status holding register file
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module std_cache_mshr_file
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_MSHR     = 4,
  parameter int unsigned ADDR_WIDTH  = 56,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ID_WIDTH    = 2,
  parameter int unsigned LINE_OFFSET = DCACHE_BYTE_OFFSET,
  localparam int unsigned IDX_W      = $clog2(NR_MSHR)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    alloc_valid_i,
  output logic                    alloc_ready_o,
  input  logic [ADDR_WIDTH-1:0]   alloc_addr_i,
  input  logic                    alloc_we_i,
  input  logic [DATA_WIDTH-1:0]   alloc_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] alloc_be_i,
  input  logic [ID_WIDTH-1:0]     alloc_id_i,
  output logic [IDX_W-1:0]        alloc_idx_o,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
  output logic                    lookup_hit_o,
  output logic [IDX_W-1:0]        lookup_idx_o,
  output logic                    issue_valid_o,
  input  logic                    issue_ready_i,
  output logic [IDX_W-1:0]        issue_idx_o,
  output logic [ADDR_WIDTH-1:0]   issue_addr_o,
  output logic                    issue_we_o,
  output logic [DATA_WIDTH-1:0]   issue_wdata_o,
  output logic [DATA_WIDTH/8-1:0] issue_be_o,
  output logic [ID_WIDTH-1:0]     issue_id_o,
  input  logic                    fill_valid_i,
  input  logic [IDX_W-1:0]        fill_idx_i,
  output logic                    fill_err_o,
  output logic [IDX_W:0]          used_o,
  output logic                    empty_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ID_WIDTH-1:0]     id;
  } mshr_entry_t;

  mshr_state_e         state_q [NR_MSHR];
  mshr_state_e         state_d [NR_MSHR];
  mshr_entry_t         entry_q [NR_MSHR];
  logic [NR_MSHR-1:0]  free_vec, conflict_vec;
  logic [IDX_W-1:0]    free_idx, head_idx;
  logic [IDX_W:0]      used_cnt;
  logic                alloc_fire, issue_fire, fill_ok, fifo_empty, fill_err_q;
  logic                unused_lookup_lo;

  assign unused_lookup_lo = ^lookup_addr_i[LINE_OFFSET-1:0];

  always_comb begin
    free_vec     = '0;
    conflict_vec = '0;
    used_cnt     = '0;
    for (int i = 0; i < NR_MSHR; i++) begin
      free_vec[i]     = (state_q[i] == MSHR_FREE);
      conflict_vec[i] = !free_vec[i] &&
        (entry_q[i].addr[ADDR_WIDTH-1:LINE_OFFSET] == alloc_addr_i[ADDR_WIDTH-1:LINE_OFFSET]);
      if (!free_vec[i]) used_cnt = used_cnt + (IDX_W + 1)'(1);
    end
  end

  if (NR_MSHR == DCACHE_SET_ASSOC) begin : g_victim
    assign free_idx = IDX_W'(one_hot_to_bin(get_victim_cl(~free_vec)));
  end else begin : g_lzc
    always_comb begin
      free_idx = '0;
      for (int i = NR_MSHR - 1; i >= 0; i--) begin
        if (free_vec[i]) free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    lookup_hit_o = 1'b0;
    lookup_idx_o = '0;
    for (int i = NR_MSHR - 1; i >= 0; i--) begin
      if (state_q[i] != MSHR_FREE &&
          entry_q[i].addr[ADDR_WIDTH-1:LINE_OFFSET] == lookup_addr_i[ADDR_WIDTH-1:LINE_OFFSET]) begin
        lookup_hit_o = 1'b1;
        lookup_idx_o = IDX_W'(i);
      end
    end
  end

  // Acceptance looks only at registered state, so a same-cycle fill never frees a slot early.
  assign alloc_ready_o = (|free_vec) && !(|conflict_vec);
  assign alloc_idx_o   = free_idx;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign issue_valid_o = !fifo_empty;
  assign issue_fire    = issue_valid_o && issue_ready_i;
  assign fill_ok       = fill_valid_i && (state_q[fill_idx_i] == MSHR_INFLIGHT);

  std_cache_mshr_file_fifo #(
    .DEPTH      (NR_MSHR),
    .DATA_WIDTH (IDX_W)
  ) i_age_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (alloc_fire),
    .data_i  (free_idx),
    .pop_i   (issue_fire),
    .data_o  (head_idx),
    .empty_o (fifo_empty)
  );

  assign issue_idx_o   = head_idx;
  assign issue_addr_o  = issue_valid_o ? entry_q[head_idx].addr  : '0;
  assign issue_we_o    = issue_valid_o ? entry_q[head_idx].we    : 1'b0;
  assign issue_wdata_o = issue_valid_o ? entry_q[head_idx].wdata : '0;
  assign issue_be_o    = issue_valid_o ? entry_q[head_idx].be    : '0;
  assign issue_id_o    = issue_valid_o ? entry_q[head_idx].id    : '0;

  always_comb begin
    state_d = state_q;
    if (alloc_fire) state_d[free_idx]   = MSHR_PENDING;
    if (issue_fire) state_d[head_idx]   = MSHR_INFLIGHT;
    if (fill_ok)    state_d[fill_idx_i] = MSHR_FREE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_MSHR; i++) state_q[i] <= MSHR_FREE;
      fill_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_err_q <= fill_valid_i && !fill_ok;
    end
  end

  // Payload needs no reset: it is only observed while its entry is non-free.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      entry_q[free_idx] <= '{addr: alloc_addr_i, we: alloc_we_i, wdata: alloc_wdata_i,
                             be: alloc_be_i, id: alloc_id_i};
    end
  end

  assign fill_err_o = fill_err_q;
  assign used_o     = used_cnt;
  assign empty_o    = &free_vec;

endmodule

`default_nettype wire

// File: tb/tb_std_cache_mshr_file.sv
// ---------------------------------------------------------------------------
// tb_std_cache_mshr_file : scoreboard bench for the MSHR file
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_std_cache_mshr_file;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alloc_valid_i;
  logic        alloc_ready_o;
  logic [55:0] alloc_addr_i;
  logic        alloc_we_i;
  logic [63:0] alloc_wdata_i;
  logic [7:0]  alloc_be_i;
  logic [1:0]  alloc_id_i;
  logic [1:0]  alloc_idx_o;
  logic [55:0] lookup_addr_i;
  logic        lookup_hit_o;
  logic [1:0]  lookup_idx_o;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [1:0]  issue_idx_o;
  logic [55:0] issue_addr_o;
  logic        issue_we_o;
  logic [63:0] issue_wdata_o;
  logic [7:0]  issue_be_o;
  logic [1:0]  issue_id_o;
  logic        fill_valid_i;
  logic [1:0]  fill_idx_i;
  logic        fill_err_o;
  logic [2:0]  used_o;
  logic        empty_o;

  typedef struct packed {
    logic [55:0] addr;
    logic [1:0]  idx;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [1:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  std_cache_mshr_file dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_addr_i  (alloc_addr_i),
    .alloc_we_i    (alloc_we_i),
    .alloc_wdata_i (alloc_wdata_i),
    .alloc_be_i    (alloc_be_i),
    .alloc_id_i    (alloc_id_i),
    .alloc_idx_o   (alloc_idx_o),
    .lookup_addr_i (lookup_addr_i),
    .lookup_hit_o  (lookup_hit_o),
    .lookup_idx_o  (lookup_idx_o),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .issue_idx_o   (issue_idx_o),
    .issue_addr_o  (issue_addr_o),
    .issue_we_o    (issue_we_o),
    .issue_wdata_o (issue_wdata_o),
    .issue_be_o    (issue_be_o),
    .issue_id_o    (issue_id_o),
    .fill_valid_i  (fill_valid_i),
    .fill_idx_i    (fill_idx_i),
    .fill_err_o    (fill_err_o),
    .used_o        (used_o),
    .empty_o       (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    alloc_valid_i = 1'b0; alloc_addr_i = '0; alloc_we_i = 1'b0; alloc_wdata_i = '0;
    alloc_be_i = '0; alloc_id_i = '0; lookup_addr_i = '0; issue_ready_i = 1'b0;
    fill_valid_i = 1'b0; fill_idx_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
  endtask

  // Drives one alloc cycle; an accepted alloc enqueues its expected issue record.
  task automatic do_alloc(input logic [55:0] a, input logic we, input logic [63:0] wd,
                          input logic [7:0] be, input logic [1:0] id,
                          input logic exp_rdy, input logic [1:0] exp_idx);
    alloc_valid_i = 1'b1; alloc_addr_i = a; alloc_we_i = we;
    alloc_wdata_i = wd; alloc_be_i = be; alloc_id_i = id;
    #1;
    checks++;
    if (alloc_ready_o !== exp_rdy) begin
      failures++;
      $display("FAIL alloc_ready addr=%h got=%b exp=%b", a, alloc_ready_o, exp_rdy);
    end
    if (exp_rdy) begin
      checks++;
      if (alloc_idx_o !== exp_idx) begin
        failures++;
        $display("FAIL alloc_idx addr=%h got=%0d exp=%0d", a, alloc_idx_o, exp_idx);
      end
      exp_q.push_back('{addr: a, idx: exp_idx, we: we, wdata: wd, be: be, id: id});
    end
    tick();
    alloc_valid_i = 1'b0;
  endtask

  // Takes the head issue and compares it against the oldest scoreboard entry.
  task automatic do_issue();
    exp_t e;
    checks++;
    if (issue_valid_o !== 1'b1 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL issue_valid got=%b exp=1 queued=%0d", issue_valid_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (issue_addr_o !== e.addr || issue_idx_o !== e.idx || issue_we_o !== e.we ||
          issue_id_o !== e.id || issue_be_o !== e.be || (e.we && issue_wdata_o !== e.wdata)) begin
        failures++;
        $display("FAIL issue_entry got addr=%h idx=%0d we=%b id=%0d be=%h wd=%h exp addr=%h idx=%0d we=%b id=%0d be=%h wd=%h",
                 issue_addr_o, issue_idx_o, issue_we_o, issue_id_o, issue_be_o, issue_wdata_o,
                 e.addr, e.idx, e.we, e.id, e.be, e.wdata);
      end
      issue_ready_i = 1'b1;
      tick();
      issue_ready_i = 1'b0;
    end
  endtask

  task automatic do_fill(input logic [1:0] idx);
    fill_valid_i = 1'b1; fill_idx_i = idx;
    tick();
    fill_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (alloc_ready_o !== 1'b1 || issue_valid_o !== 1'b0 || lookup_hit_o !== 1'b0 ||
        fill_err_o !== 1'b0 || used_o !== 3'd0 || empty_o !== 1'b1 ||
        alloc_idx_o !== 2'd0 || issue_idx_o !== 2'd0 || lookup_idx_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b iv=%b hit=%b ferr=%b used=%0d empty=%b aidx=%0d iidx=%0d lidx=%0d exp 1 0 0 0 0 1 0 0 0",
               alloc_ready_o, issue_valid_o, lookup_hit_o, fill_err_o, used_o, empty_o,
               alloc_idx_o, issue_idx_o, lookup_idx_o);
    end
  endtask

  task automatic test_basic();
    do_reset();
    do_alloc(56'h1000, 1'b0, 64'h0, 8'h00, 2'd1, 1'b1, 2'd0);
    checks++;
    if (issue_valid_o !== 1'b1 || issue_addr_o !== 56'h1000 || used_o !== 3'd1 || empty_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_after_alloc got iv=%b addr=%h used=%0d empty=%b exp 1 1000 1 0",
               issue_valid_o, issue_addr_o, used_o, empty_o);
    end
    do_issue();
    do_fill(2'd0);
    checks++;
    if (empty_o !== 1'b1 || used_o !== 3'd0 || fill_err_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_retire got empty=%b used=%0d ferr=%b exp 1 0 0", empty_o, used_o, fill_err_o);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    do_alloc(56'h1000, 1'b1, 64'hDEAD_BEEF_0123_4567, 8'h0F, 2'd2, 1'b1, 2'd0);
    do_alloc(56'h1008, 1'b0, 64'h0, 8'h00, 2'd0, 1'b0, 2'd0);
    lookup_addr_i = 56'h100C;
    #1;
    checks++;
    if (lookup_hit_o !== 1'b1 || lookup_idx_o !== 2'd0) begin
      failures++;
      $display("FAIL lookup_same_line got hit=%b idx=%0d exp 1 0", lookup_hit_o, lookup_idx_o);
    end
    lookup_addr_i = 56'h2000;
    #1;
    checks++;
    if (lookup_hit_o !== 1'b0) begin
      failures++;
      $display("FAIL lookup_miss got hit=%b exp 0", lookup_hit_o);
    end
    do_alloc(56'h1010, 1'b0, 64'h0, 8'h00, 2'd3, 1'b1, 2'd1);
    lookup_addr_i = 56'h1014;
    #1;
    checks++;
    if (lookup_hit_o !== 1'b1 || lookup_idx_o !== 2'd1) begin
      failures++;
      $display("FAIL lookup_next_line got hit=%b idx=%0d exp 1 1", lookup_hit_o, lookup_idx_o);
    end
    do_issue();
    do_issue();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++)
      do_alloc(56'h100 * (i + 1), 1'b0, 64'h0, 8'h00, 2'(i), 1'b1, 2'(i));
    checks++;
    if (used_o !== 3'd4 || empty_o !== 1'b0) begin
      failures++;
      $display("FAIL full_used got used=%0d empty=%b exp 4 0", used_o, empty_o);
    end
    do_alloc(56'h500, 1'b0, 64'h0, 8'h00, 2'd0, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) do_issue();
    alloc_valid_i = 1'b1; alloc_addr_i = 56'h500; alloc_id_i = 2'd1;
    fill_valid_i = 1'b1; fill_idx_i = 2'd2;
    #1;
    checks++;
    if (alloc_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL no_same_cycle_reuse got rdy=%b exp 0", alloc_ready_o);
    end
    tick();
    alloc_valid_i = 1'b0; fill_valid_i = 1'b0;
    checks++;
    if (used_o !== 3'd3) begin
      failures++;
      $display("FAIL full_after_fill got used=%0d exp 3", used_o);
    end
    do_alloc(56'h500, 1'b0, 64'h0, 8'h00, 2'd1, 1'b1, 2'd2);
    do_issue();
  endtask

  task automatic test_order();
    exp_t e;
    do_reset();
    do_alloc(56'h1000, 1'b0, 64'h0, 8'h00, 2'd0, 1'b1, 2'd0);
    do_alloc(56'h2000, 1'b0, 64'h0, 8'h00, 2'd1, 1'b1, 2'd1);
    do_alloc(56'h3000, 1'b0, 64'h0, 8'h00, 2'd2, 1'b1, 2'd2);
    do_issue();
    do_issue();
    do_fill(2'd1);
    do_alloc(56'h4000, 1'b1, 64'h0BAD_F00D_0000_0001, 8'hF0, 2'd3, 1'b1, 2'd1);
    do_issue();
    do_issue();
    do_fill(2'd0);
    do_alloc(56'h5000, 1'b0, 64'h0, 8'h00, 2'd0, 1'b1, 2'd0);
    do_fill(2'd0);
    checks++;
    if (fill_err_o !== 1'b1) begin
      failures++;
      $display("FAIL fill_pending_err got=%b exp 1", fill_err_o);
    end
    // Same cycle: alloc into idx 3, issue the 0x5000 entry, retire idx 2.
    alloc_valid_i = 1'b1; alloc_addr_i = 56'h6000; alloc_we_i = 1'b0; alloc_id_i = 2'd1;
    alloc_be_i = 8'h00;
    issue_ready_i = 1'b1;
    fill_valid_i = 1'b1; fill_idx_i = 2'd2;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (alloc_ready_o !== 1'b1 || alloc_idx_o !== 2'd3 || issue_valid_o !== 1'b1 ||
        issue_addr_o !== e.addr || issue_idx_o !== e.idx) begin
      failures++;
      $display("FAIL concurrent_ops got rdy=%b aidx=%0d iv=%b iaddr=%h iidx=%0d exp 1 3 1 %h %0d",
               alloc_ready_o, alloc_idx_o, issue_valid_o, issue_addr_o, issue_idx_o, e.addr, e.idx);
    end
    exp_q.push_back('{addr: 56'h6000, idx: 2'd3, we: 1'b0, wdata: 64'h0, be: 8'h00, id: 2'd1});
    tick();
    alloc_valid_i = 1'b0; issue_ready_i = 1'b0; fill_valid_i = 1'b0;
    checks++;
    if (used_o !== 3'd3) begin
      failures++;
      $display("FAIL concurrent_used got=%0d exp 3", used_o);
    end
    do_issue();
  endtask

  task automatic test_fill_err();
    do_reset();
    for (int i = 0; i < 4; i++)
      do_alloc(56'h10000 + 56'h40 * i, 1'b0, 64'h0, 8'h00, 2'(3 - i), 1'b1, 2'(i));
    checks++;
    if (fill_err_o !== 1'b0) begin
      failures++;
      $display("FAIL fill_err_idle got=%b exp 0", fill_err_o);
    end
    do_fill(2'd3);
    checks++;
    if (fill_err_o !== 1'b1) begin
      failures++;
      $display("FAIL fill_err_pulse got=%b exp 1", fill_err_o);
    end
    tick();
    checks++;
    if (fill_err_o !== 1'b0 || used_o !== 3'd4) begin
      failures++;
      $display("FAIL fill_err_clear got ferr=%b used=%0d exp 0 4", fill_err_o, used_o);
    end
    for (int i = 0; i < 4; i++) do_issue();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++)
      do_alloc(56'h800 * (i + 1), 1'b0, 64'h0, 8'h00, 2'd0, 1'b1, 2'(i));
    for (int i = 0; i < 3; i++) do_issue();
    rst_i = 1'b1;
    alloc_valid_i = 1'b1; alloc_addr_i = 56'h9000;
    fill_valid_i = 1'b1; fill_idx_i = 2'd3;
    issue_ready_i = 1'b1;
    tick();
    alloc_valid_i = 1'b0; fill_valid_i = 1'b0; issue_ready_i = 1'b0;
    checks++;
    if (empty_o !== 1'b1 || used_o !== 3'd0 || issue_valid_o !== 1'b0 || fill_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got empty=%b used=%0d iv=%b ferr=%b exp 1 0 0 0",
               empty_o, used_o, issue_valid_o, fill_err_o);
    end
    rst_i = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (alloc_ready_o !== 1'b1 || alloc_idx_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_ready got rdy=%b idx=%0d exp 1 0", alloc_ready_o, alloc_idx_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_full();
    test_order();
    test_fill_err();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
